// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in serial-out transmitter with valid/ready load and MSB/LSB-first order
module piso_serializer #(
    parameter int WIDTH        = 4,
    parameter int CLKS_PER_BIT = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] data_in,
    input  logic             dir_in,
    input  logic             shift_en,
    output logic             serial_out,
    output logic             shift_valid,
    output logic             busy,
    output logic             done
);
    localparam int BW = $clog2(WIDTH);
    localparam int CW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);
    localparam logic [CW-1:0] LAST_CLK = CW'(CLKS_PER_BIT - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t          state, state_nx;
    logic [WIDTH-1:0] sreg, sreg_nx;
    logic            dir, dir_nx;
    logic [BW-1:0]   bit_cnt, bit_cnt_nx;
    logic [CW-1:0]   clk_cnt, clk_cnt_nx;
    logic            done_nx;
    logic            advance;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            sreg    <= '0;
            dir     <= 1'b0;
            bit_cnt <= '0;
            clk_cnt <= '0;
            done    <= 1'b0;
        end else begin
            state   <= state_nx;
            sreg    <= sreg_nx;
            dir     <= dir_nx;
            bit_cnt <= bit_cnt_nx;
            clk_cnt <= clk_cnt_nx;
            done    <= done_nx;
        end
    end

    // advance is the edge at which the current bit period ends
    assign advance = (state == SHIFT) && shift_en && (clk_cnt == LAST_CLK);

    always_comb begin
        state_nx   = state;
        sreg_nx    = sreg;
        dir_nx     = dir;
        bit_cnt_nx = bit_cnt;
        clk_cnt_nx = clk_cnt;
        done_nx    = 1'b0;
        if (state == IDLE && load_valid) begin
            state_nx   = SHIFT;
            sreg_nx    = data_in;
            dir_nx     = dir_in;
            bit_cnt_nx = '0;
            clk_cnt_nx = '0;
        end else if (state == SHIFT && shift_en) begin
            clk_cnt_nx = advance ? '0 : clk_cnt + 1'b1;
            if (advance) begin
                sreg_nx    = dir ? sreg << 1 : sreg >> 1;
                bit_cnt_nx = bit_cnt == LAST_BIT ? '0 : bit_cnt + 1'b1;
                state_nx   = bit_cnt == LAST_BIT ? IDLE : SHIFT;
                done_nx    = bit_cnt == LAST_BIT;
            end
        end
    end

    assign load_ready  = state == IDLE;
    assign busy        = state == SHIFT;
    assign shift_valid = state == SHIFT;
    assign serial_out  = (state == SHIFT) && (dir ? sreg[WIDTH-1] : sreg[0]);
endmodule
